// File: rtl/alpaca_axis_frame_capture_if.sv
// AXI-Stream sample bus feeding the frame-capture buffer.
// The master drives data/valid/last; the capture block (slave) drives ready.
interface alpaca_axis_frame_capture_if #(
  parameter int SAMP_PER_CLK = 2,
  parameter int WIDTH        = 16
);
  logic [SAMP_PER_CLK*WIDTH-1:0] tdata;
  logic                          tvalid;
  logic                          tready;
  logic                          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/alpaca_axis_frame_capture.sv
// AXIS frame-capture buffer: sync on tlast, optional frame skip, capture FRAMES frames, police tlast.
// Optional ramp checker on captured beats is enabled with ALPACA_CAPTURE_RAMP_CHECK_EN.
module alpaca_axis_frame_capture #(
  parameter int SAMP_PER_CLK = 2,
  parameter int WIDTH        = 16,
  parameter int FRAME_LEN    = 64,
  parameter int FRAMES       = 2,
  parameter int SKIP_FRAMES  = 0,
  localparam int DEPTH       = FRAMES * FRAME_LEN,
  localparam int AW          = $clog2(DEPTH),
  localparam int FCW         = $clog2(FRAMES + 1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           en,
  alpaca_axis_frame_capture_if.slave     s_axis,
  input  logic                           rd_en,
  input  logic [AW-1:0]                  rd_addr,
  output logic [SAMP_PER_CLK*WIDTH-1:0]  rd_data,
  output logic                           full,
  output logic                           busy,
  output logic [FCW-1:0]                 frame_cnt,
  output logic [15:0]                    err_tlast_unexp,
  output logic [15:0]                    err_tlast_miss,
  output logic [15:0]                    err_data
);

  localparam int DW  = SAMP_PER_CLK * WIDTH;
  localparam int BW  = $clog2(FRAME_LEN);
  localparam int SKW = $clog2(SKIP_FRAMES + 2);
  localparam logic [BW-1:0]  BEAT_LAST  = BW'(FRAME_LEN - 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES - 1);
  localparam logic [SKW-1:0] SKIP_LAST  = SKW'(SKIP_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, SYNC, SKIP, CAP, FULL} state_t;

  state_t          state_reg, state_next;
  logic            tready_reg;
  logic [BW-1:0]   beat_idx_reg, beat_idx_next;
  logic [SKW-1:0]  skip_cnt_reg, skip_cnt_next;
  logic [FCW-1:0]  frame_cnt_reg, frame_cnt_next;
  logic [AW-1:0]   wr_addr_reg, wr_addr_next;
  logic [15:0]     unexp_reg, miss_reg;
  logic [DW-1:0]   rd_data_reg;
  logic            wr_en, unexp_inc, miss_inc;
  logic            beat_ok, early_tlast, frame_close;
  logic [AW-1:0]   frame_base;

  logic [DW-1:0]   mem [DEPTH];

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  assign beat_ok     = s_axis.tvalid & tready_reg;
  assign early_tlast = beat_ok & s_axis.tlast & (beat_idx_reg != BEAT_LAST);
  assign frame_close = beat_ok & (beat_idx_reg == BEAT_LAST);
  assign frame_base  = AW'(32'(frame_cnt_reg) * FRAME_LEN);

  always_comb begin
    state_next     = state_reg;
    beat_idx_next  = beat_idx_reg;
    skip_cnt_next  = skip_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    wr_addr_next   = wr_addr_reg;
    wr_en          = 1'b0;
    unexp_inc      = 1'b0;
    miss_inc       = 1'b0;
    case (state_reg)
      IDLE: if (en) state_next = SYNC;
      SYNC: begin
        if (beat_ok && s_axis.tlast) begin
          beat_idx_next = '0;
          state_next    = (SKIP_FRAMES > 0) ? SKIP : CAP;
        end
      end
      SKIP: begin
        if (early_tlast) begin
          unexp_inc     = 1'b1;
          beat_idx_next = '0;
        end else if (frame_close) begin
          miss_inc      = ~s_axis.tlast;
          beat_idx_next = '0;
          if (skip_cnt_reg == SKIP_LAST) begin
            skip_cnt_next = '0;
            state_next    = CAP;
          end else begin
            skip_cnt_next = skip_cnt_reg + 1'b1;
          end
        end else if (beat_ok) begin
          beat_idx_next = beat_idx_reg + 1'b1;
        end
      end
      CAP: begin
        // Early tlast drops the partial frame: no write, rewind to the frame base.
        if (early_tlast) begin
          unexp_inc     = 1'b1;
          beat_idx_next = '0;
          wr_addr_next  = frame_base;
        end else if (beat_ok) begin
          wr_en = 1'b1;
          if (frame_close) begin
            miss_inc       = ~s_axis.tlast;
            beat_idx_next  = '0;
            frame_cnt_next = frame_cnt_reg + 1'b1;
            if (frame_cnt_reg == FRAME_LAST) state_next = FULL;
            else wr_addr_next = wr_addr_reg + 1'b1;
          end else begin
            beat_idx_next = beat_idx_reg + 1'b1;
            wr_addr_next  = wr_addr_reg + 1'b1;
          end
        end
      end
      FULL: state_next = FULL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      tready_reg    <= 1'b0;
      beat_idx_reg  <= '0;
      skip_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      wr_addr_reg   <= '0;
      unexp_reg     <= '0;
      miss_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      tready_reg    <= 1'b1;
      beat_idx_reg  <= beat_idx_next;
      skip_cnt_reg  <= skip_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      wr_addr_reg   <= wr_addr_next;
      unexp_reg     <= sat_inc(unexp_reg, unexp_inc);
      miss_reg      <= sat_inc(miss_reg, miss_inc);
    end
  end

  // Buffer RAM is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_reg] <= s_axis.tdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
  end

`ifdef ALPACA_CAPTURE_RAMP_CHECK_EN
  logic [WIDTH-1:0]        ramp_ref;
  logic [SAMP_PER_CLK-1:0] lane_bad;
  logic                    data_bad_reg;
  logic [15:0]             err_data_reg;

  // The ramp reference tracks wr_addr, so it rewinds along with it.
  assign ramp_ref = WIDTH'(32'(wr_addr_reg) * SAMP_PER_CLK);

  generate
    for (genvar gi = 0; gi < SAMP_PER_CLK; gi++) begin : g_lane
      assign lane_bad[gi] = s_axis.tdata[(SAMP_PER_CLK-gi)*WIDTH-1 -: WIDTH] != ramp_ref + WIDTH'(gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_bad_reg <= 1'b0;
      err_data_reg <= '0;
    end else begin
      data_bad_reg <= wr_en & (|lane_bad);
      err_data_reg <= sat_inc(err_data_reg, data_bad_reg);
    end
  end

  assign err_data = err_data_reg;
`else
  assign err_data = '0;
`endif

  assign s_axis.tready   = tready_reg;
  assign rd_data         = rd_data_reg;
  assign full            = (state_reg == FULL);
  assign busy            = (state_reg == SYNC) || (state_reg == SKIP) || (state_reg == CAP);
  assign frame_cnt       = frame_cnt_reg;
  assign err_tlast_unexp = unexp_reg;
  assign err_tlast_miss  = miss_reg;

endmodule

// File: tb/tb_alpaca_axis_frame_capture.sv
// Directed bench: dut_a uses default parameters, dut_b skips 3 frames; both see the same stream.
module tb_alpaca_axis_frame_capture;

  logic        clk = 1'b0;
  logic        rstn, en, rd_en;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data_a, rd_data_b;
  logic        full_a, full_b, busy_a, busy_b;
  logic [1:0]  frame_cnt_a, frame_cnt_b;
  logic [15:0] unexp_a, unexp_b, miss_a, miss_b, derr_a, derr_b;
  int          n_checks = 0;
  int          n_errors = 0;

`ifdef ALPACA_CAPTURE_RAMP_CHECK_EN
  localparam logic [15:0] EXP_DATA_ERR = 16'd1;
`else
  localparam logic [15:0] EXP_DATA_ERR = 16'd0;
`endif

  always #5 clk = ~clk;

  alpaca_axis_frame_capture_if #(.SAMP_PER_CLK(2), .WIDTH(16)) axis_a ();
  alpaca_axis_frame_capture_if #(.SAMP_PER_CLK(2), .WIDTH(16)) axis_b ();

  alpaca_axis_frame_capture dut_a (
    .clk(clk), .rstn(rstn), .en(en), .s_axis(axis_a),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .full(full_a), .busy(busy_a), .frame_cnt(frame_cnt_a),
    .err_tlast_unexp(unexp_a), .err_tlast_miss(miss_a), .err_data(derr_a)
  );

  alpaca_axis_frame_capture #(.SKIP_FRAMES(3)) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .s_axis(axis_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .full(full_b), .busy(busy_b), .frame_cnt(frame_cnt_b),
    .err_tlast_unexp(unexp_b), .err_tlast_miss(miss_b), .err_data(derr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] ramp(input int n);
    logic [15:0] l0, l1;
    l0 = 16'(2 * n);
    l1 = 16'(2 * n + 1);
    return {l0, l1};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    axis_a.tvalid = v; axis_a.tdata = d; axis_a.tlast = l;
    axis_b.tvalid = v; axis_b.tdata = d; axis_b.tlast = l;
    @(posedge clk); #1;
  endtask

  // Sends nbeats ramp beats starting at ramp index base_n; tlast on beat last_at (-1: none).
  task automatic send_frame(input int base_n, input int nbeats, input int last_at,
                            input int bad_at, input bit gaps);
    logic [31:0] d;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) drive(1'b0, 32'h0, 1'b0);
      d = ramp(base_n + b);
      if (b == bad_at) d[15:0] = 16'hBEEF;
      drive(1'b1, d, b == last_at);
    end
    axis_a.tvalid = 1'b0;
    axis_b.tvalid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0; en = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic arm_and_sync();
    rstn = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    drive(1'b1, 32'hDEAD0000, 1'b1);
    axis_a.tvalid = 1'b0;
    axis_b.tvalid = 1'b0;
  endtask

  task automatic read_a(input int addr, input logic [31:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = 7'(addr);
    @(posedge clk); #1;
    rd_en = 1'b0;
    check(tag, rd_data_a, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tready"}, {31'd0, axis_a.tready}, 32'd0);
    check({tag, "_full"},   {31'd0, full_a}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy_a}, 32'd0);
    check({tag, "_fcnt"},   {30'd0, frame_cnt_a}, 32'd0);
    check({tag, "_unexp"},  {16'd0, unexp_a}, 32'd0);
    check({tag, "_miss"},   {16'd0, miss_a}, 32'd0);
    check({tag, "_derr"},   {16'd0, derr_a}, 32'd0);
    check({tag, "_rdata"},  rd_data_a, 32'd0);
  endtask

  initial begin
    rd_en = 1'b0; rd_addr = '0;
    axis_a.tvalid = 1'b0; axis_a.tdata = '0; axis_a.tlast = 1'b0;
    axis_b.tvalid = 1'b0; axis_b.tdata = '0; axis_b.tlast = 1'b0;

    // Clean two-frame capture, continuous valid.
    do_reset(4);
    check_reset_state("rst");
    arm_and_sync();
    check("t1_busy", {31'd0, busy_a}, 32'd1);
    send_frame(0, 64, 63, -1, 1'b0);
    check("t1_fcnt_mid", {30'd0, frame_cnt_a}, 32'd1);
    check("t1_full_mid", {31'd0, full_a}, 32'd0);
    send_frame(64, 64, 63, -1, 1'b0);
    check("t1_full", {31'd0, full_a}, 32'd1);
    check("t1_fcnt", {30'd0, frame_cnt_a}, 32'd2);
    check("t1_busy_end", {31'd0, busy_a}, 32'd0);
    read_a(0, ramp(0), "t1_ram0");
    read_a(5, ramp(5), "t1_ram5");
    read_a(64, ramp(64), "t1_ram64");
    read_a(127, ramp(127), "t1_ram127");
    rd_addr = 7'd3;
    @(posedge clk); #1;
    check("t1_rd_hold", rd_data_a, ramp(127));

    // Keep streaming: dut_a stays full, dut_b skips 3 frames then captures.
    send_frame(128, 64, 63, -1, 1'b0);
    send_frame(192, 64, 63, -1, 1'b0);
    send_frame(256, 64, 63, -1, 1'b0);
    check("t1_full_hold", {31'd0, full_a}, 32'd1);
    check("t1_fcnt_hold", {30'd0, frame_cnt_a}, 32'd2);
    check("t1_unexp", {16'd0, unexp_a}, 32'd0);
    check("t1_miss", {16'd0, miss_a}, 32'd0);
    check("t1_derr", {16'd0, derr_a}, 32'd0);
    check("t4_full_b", {31'd0, full_b}, 32'd1);
    check("t4_fcnt_b", {30'd0, frame_cnt_b}, 32'd2);
    rd_en = 1'b1; rd_addr = 7'd0;
    @(posedge clk); #1;
    check("t4_ram0_b", rd_data_b, ramp(192));
    rd_addr = 7'd127;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("t4_ram127_b", rd_data_b, ramp(319));

    // Reset for one cycle in the middle of a CAP frame.
    do_reset(1);
    arm_and_sync();
    send_frame(0, 20, -1, -1, 1'b0);
    check("t5_busy_pre", {31'd0, busy_a}, 32'd1);
    do_reset(1);
    check_reset_state("t5");

    // Early tlast at beat 10 of frame 1, 50% valid duty.
    arm_and_sync();
    send_frame(0, 64, 63, -1, 1'b1);
    send_frame(64, 11, 10, -1, 1'b1);
    check("t2_unexp", {16'd0, unexp_a}, 32'd1);
    check("t2_fcnt_mid", {30'd0, frame_cnt_a}, 32'd1);
    check("t2_full_mid", {31'd0, full_a}, 32'd0);
    send_frame(64, 64, 63, -1, 1'b1);
    check("t2_full", {31'd0, full_a}, 32'd1);
    check("t2_fcnt", {30'd0, frame_cnt_a}, 32'd2);
    check("t2_derr", {16'd0, derr_a}, 32'd0);
    read_a(5, ramp(5), "t2_ram5");
    read_a(64, ramp(64), "t2_ram64");
    read_a(74, ramp(74), "t2_ram74");
    read_a(127, ramp(127), "t2_ram127");

    // Missing tlast at beat 63 of frame 0, plus a corrupted lane 1 on beat 5.
    do_reset(1);
    arm_and_sync();
    send_frame(0, 64, -1, 5, 1'b0);
    check("t3_miss", {16'd0, miss_a}, 32'd1);
    check("t3_unexp", {16'd0, unexp_a}, 32'd0);
    check("t3_fcnt_mid", {30'd0, frame_cnt_a}, 32'd1);
    send_frame(64, 64, 63, -1, 1'b0);
    check("t3_full", {31'd0, full_a}, 32'd1);
    read_a(64, ramp(64), "t3_ram64");
    read_a(5, {16'd10, 16'hBEEF}, "t6_ram5_bad");
    read_a(6, ramp(6), "t6_ram6");
    check("t6_derr", {16'd0, derr_a}, {16'd0, EXP_DATA_ERR});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
